// File: rtl/reg_file.sv
// rtl/reg_file.sv - multicycle CPU register file, two read ports, one write port, debug read
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_live;
  logic              wr_commit;
  logic              hit_a;
  logic              hit_b;
  logic              hit_dbg;

  // wr_live drives the bypass path; wr_commit additionally respects reset
  assign wr_live   = wr_en && (wr_addr != '0);
  assign wr_commit = wr_live && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '{default: '0};
      wr_count <= '0;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
      if (wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign hit_a   = (BYPASS != 0) && wr_live && (rd_addr_a == wr_addr);
  assign hit_b   = (BYPASS != 0) && wr_live && (rd_addr_b == wr_addr);
  assign hit_dbg = (BYPASS != 0) && wr_live && (dbg_addr == wr_addr);

  // Entry 0 is masked on read so it is zero even before the first reset
  assign rd_data_a = (rd_addr_a == '0) ? '0 : (hit_a   ? wr_data : mem[rd_addr_a]);
  assign rd_data_b = (rd_addr_b == '0) ? '0 : (hit_b   ? wr_data : mem[rd_addr_b]);
  assign dbg_data  = (dbg_addr  == '0) ? '0 : (hit_dbg ? wr_data : mem[dbg_addr]);

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file for the multicycle CPU.
- Sources the 32-bit operands that the A and B operand registers latch during the decode cycle.
- Accepts write-back data from ALUOut or MDR at the end of R-type, I-type and load instructions.
- Two combinational read ports, one synchronous write port, and one combinational debug read port for the testbench and LED/monitor logic.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- BYPASS, 1, when 1 a read of the address being written in the same cycle returns wr_data (write-through); when 0 it returns the stored old value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- rd_addr_a  input  ADDR_W  read index for port A (instruction rs field).
- rd_data_a  output  DATA_W  combinational read data for port A.
- rd_addr_b  input  ADDR_W  read index for port B (instruction rt field).
- rd_data_b  output  DATA_W  combinational read data for port B.
- wr_en  input  1  write enable (RegWrite from the control FSM).
- wr_addr  input  ADDR_W  write index (rd or rt, chosen by RegDst mux upstream).
- wr_data  input  DATA_W  write-back data (MemtoReg mux output).
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  combinational debug read data.
- wr_count  output  16  number of committed writes since reset, saturating.

Behaviour:
- Storage: 2**ADDR_W entries of DATA_W bits.
- Entry 0 is hard-wired zero: writes to address 0 are discarded, and reads of address 0 always return 0 regardless of BYPASS.
- Reset: on a rising edge with rst=1, every entry clears to 0 and wr_count clears to 0 in that same cycle.
  - A wr_en asserted in the reset cycle is ignored (reset wins).
  - After the reset edge, all read ports return 0 for every address.
- Write: on a rising edge with rst=0, wr_en=1 and wr_addr!=0, entry[wr_addr] <= wr_data.
  - The write is visible on read ports from the following cycle (combinational read of stored value).
- Read: rd_data_a, rd_data_b and dbg_data are purely combinational functions of the address inputs and the stored array; zero latency.
  - This allows the A/B operand registers to latch on the edge ending the decode cycle.
- Bypass, BYPASS=1: if wr_en=1, wr_addr!=0 and a read address equals wr_addr, that port returns wr_data in the same cycle. Applies independently to ports A, B and dbg.
- Bypass, BYPASS=0: the same condition returns the pre-write stored value; the new value is visible next cycle.
- Simultaneous reads: both ports may read the same address, and each returns identical data.
- wr_count: increments by 1 on each committed write (wr_en=1, wr_addr!=0, rst=0).
  - Saturates at 16'hFFFF with no wrap.
  - Writes to address 0 do not count.
- X-safety: with wr_en=0, wr_addr and wr_data are don't-care and must not alter state.
- No internal FSM is exposed to the control unit. The control unit guarantees wr_en is a single-cycle pulse per write-back state; back-to-back wr_en cycles are legal and each commits.

Test Plan:
- Reset clear: preload r5=32'hDEADBEEF, assert rst one cycle with wr_en=1, wr_addr=5, wr_data=32'h1 -> next cycle rd_data_a(addr 5)=0, wr_count=0.
- Write/read: write r7=32'h12345678 then r8=32'hCAFEF00D on consecutive cycles -> rd_data_a(7)=32'h12345678 and rd_data_b(8)=32'hCAFEF00D; wr_count=2.
- Zero register: write r0=32'hFFFFFFFF -> rd_data_a(0)=0 and rd_data_b(0)=0, including during the write cycle; wr_count unchanged.
- Bypass: with r3=32'hAAAA0000, present wr_en=1, wr_addr=3, wr_data=32'h5555 with rd_addr_a=3 in the same cycle:
  - BYPASS=1 -> rd_data_a=32'h5555 in that cycle.
  - BYPASS=0 -> rd_data_a=32'hAAAA0000 in that cycle, then 32'h5555 the next cycle.
- Dual-port same address: rd_addr_a=rd_addr_b=dbg_addr=31 after writing r31=32'h0BADC0DE -> all three outputs equal 32'h0BADC0DE.
- Saturation: force 65,537 committed writes to r1 -> wr_count holds 16'hFFFF; a subsequent rst returns it to 0.
